pma_region_table: RTL

Runtime-programmable physical memory attribute (PMA) table. It replaces the static cached, executable and non-idempotent region rules, which are currently fixed at elaboration, with `NrRules` writable entries. Reset contents come from parameters. The block sits beside the CSR file. It answers registered address lookups from the fetch and load/store paths with hit, rule index and attribute flags.

---
 rtl/pma_region_table_if.sv | 40 ++++
 rtl/pma_region_table.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pma_region_table_if.sv
// Config and lookup bus of the runtime-programmable PMA region table.
interface pma_region_table_if #(
  parameter int AddrWidth = 64,
  parameter int IdxW      = 2
);
  logic                 cfg_we_i;
  logic                 cfg_re_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [1:0]           cfg_sel_i;
  logic [AddrWidth-1:0] cfg_wdata_i;
  logic [AddrWidth-1:0] cfg_rdata_o;
  logic                 cfg_rvalid_o;
  logic                 cfg_err_o;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic                 rsp_hit_o;
  logic [IdxW-1:0]      rsp_idx_o;
  logic                 rsp_cached_o;
  logic                 rsp_exec_o;
  logic                 rsp_nonidem_o;

  modport master (
    output cfg_we_i, cfg_re_i, cfg_idx_i, cfg_sel_i, cfg_wdata_i,
    input  cfg_rdata_o, cfg_rvalid_o, cfg_err_o,
    output req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_idx_o,
    input  rsp_cached_o, rsp_exec_o, rsp_nonidem_o
  );

  modport slave (
    input  cfg_we_i, cfg_re_i, cfg_idx_i, cfg_sel_i, cfg_wdata_i,
    output cfg_rdata_o, cfg_rvalid_o, cfg_err_o,
    input  req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_idx_o,
    output rsp_cached_o, rsp_exec_o, rsp_nonidem_o
  );
endinterface

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table: writable base/length/attr entries with
// lockable attributes and a single-register lookup stage with valid/ready.
module pma_region_table #(
  parameter int                           NrRules   = 4,
  parameter int                           AddrWidth = 64,
  parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules*8-1:0]         RstAttr   = '0,
  parameter int                           IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  pma_region_table_if.slave bus
);

  // Bits 6:4 of the attr byte are not stored so they always read back as 0.
  localparam logic [7:0] AttrMask = 8'h8F;
  localparam int BitCached  = 0;
  localparam int BitExec    = 1;
  localparam int BitNonidem = 2;
  localparam int BitEnable  = 3;
  localparam int BitLock    = 7;

  logic [AddrWidth-1:0] base_tbl [NrRules];
  logic [AddrWidth-1:0] len_tbl  [NrRules];
  logic [7:0]           attr_tbl [NrRules];

  // Offset-based compare: base + length is never formed, so top-of-space regions work.
  function automatic logic region_match(input logic [AddrWidth-1:0] addr,
                                        input logic [AddrWidth-1:0] base,
                                        input logic [AddrWidth-1:0] len,
                                        input logic                 en);
    logic [AddrWidth-1:0] offs;
    offs = addr - base;
    return en && (len != '0) && (addr >= base) && (offs < len);
  endfunction

  logic                 idx_ok;
  logic                 sel_ok;
  logic                 acc_ok;
  logic                 cur_lock;
  logic [AddrWidth-1:0] cur_field;
  logic                 wr_en;
  logic                 err_d;

  always_comb begin
    idx_ok    = 1'b0;
    cur_lock  = 1'b0;
    cur_field = '0;
    for (int i = 0; i < NrRules; i++) begin
      if (bus.cfg_idx_i == IdxW'(i)) begin
        idx_ok   = 1'b1;
        cur_lock = attr_tbl[i][BitLock];
        case (bus.cfg_sel_i)
          2'd0:    cur_field = base_tbl[i];
          2'd1:    cur_field = len_tbl[i];
          2'd2:    cur_field = AddrWidth'(attr_tbl[i]);
          default: cur_field = '0;
        endcase
      end
    end
  end

  assign sel_ok = (bus.cfg_sel_i != 2'd3);
  assign acc_ok = idx_ok && sel_ok;
  assign wr_en  = bus.cfg_we_i && acc_ok && !cur_lock;
  assign err_d  = (bus.cfg_we_i && !wr_en) || (bus.cfg_re_i && !acc_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_tbl[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_tbl[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_tbl[i] <= RstAttr[i*8 +: 8] & AttrMask;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NrRules; i++) begin
        if (bus.cfg_idx_i == IdxW'(i)) begin
          case (bus.cfg_sel_i)
            2'd0:    base_tbl[i] <= bus.cfg_wdata_i;
            2'd1:    len_tbl[i]  <= bus.cfg_wdata_i;
            2'd2:    attr_tbl[i] <= bus.cfg_wdata_i[7:0] & AttrMask;
            default: ;
          endcase
        end
      end
    end
  end

  // Lowest index wins: the descending scan lets lower entries overwrite higher ones.
  logic            hit_d;
  logic [IdxW-1:0] idx_d;
  logic            cached_d;
  logic            exec_d;
  logic            nonidem_d;

  always_comb begin
    hit_d     = 1'b0;
    idx_d     = '0;
    cached_d  = 1'b0;
    exec_d    = 1'b0;
    nonidem_d = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (region_match(bus.req_addr_i, base_tbl[i], len_tbl[i], attr_tbl[i][BitEnable])) begin
        hit_d     = 1'b1;
        idx_d     = IdxW'(i);
        cached_d  = attr_tbl[i][BitCached];
        exec_d    = attr_tbl[i][BitExec];
        nonidem_d = attr_tbl[i][BitNonidem];
      end
    end
  end

  // ---- stage p1: registered lookup response and config read/err ----
  logic                 vld_p1;
  logic                 hit_p1;
  logic [IdxW-1:0]      idx_p1;
  logic                 cached_p1;
  logic                 exec_p1;
  logic                 nonidem_p1;
  logic [AddrWidth-1:0] rdata_p1;
  logic                 rvalid_p1;
  logic                 err_p1;
  logic                 accept;

  assign bus.req_ready_o = !vld_p1 || bus.rsp_ready_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      hit_p1     <= 1'b0;
      idx_p1     <= '0;
      cached_p1  <= 1'b0;
      exec_p1    <= 1'b0;
      nonidem_p1 <= 1'b0;
      rdata_p1   <= '0;
      rvalid_p1  <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      if (accept) begin
        vld_p1     <= 1'b1;
        hit_p1     <= hit_d;
        idx_p1     <= idx_d;
        cached_p1  <= cached_d;
        exec_p1    <= exec_d;
        nonidem_p1 <= nonidem_d;
      end else if (bus.rsp_ready_i) begin
        vld_p1 <= 1'b0;
      end
      if (bus.cfg_re_i) begin
        rdata_p1 <= cur_field;
      end
      rvalid_p1 <= bus.cfg_re_i;
      err_p1    <= err_d;
    end
  end

  assign bus.rsp_valid_o   = vld_p1;
  assign bus.rsp_hit_o     = hit_p1;
  assign bus.rsp_idx_o     = idx_p1;
  assign bus.rsp_cached_o  = cached_p1;
  assign bus.rsp_exec_o    = exec_p1;
  assign bus.rsp_nonidem_o = nonidem_p1;
  assign bus.cfg_rdata_o   = rdata_p1;
  assign bus.cfg_rvalid_o  = rvalid_p1;
  assign bus.cfg_err_o     = err_p1;

endmodule
